// File: rtl/piso_32bit_if.sv
// Load/shift/serial-out bundle between the word producer, the PISO and the bit consumer.
interface piso_32bit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] d;
   logic             load_valid;
   logic             load_ready;
   logic             shift_en;
   logic             sout;
   logic             sout_valid;
   logic             done;
   logic             busy;

   // Producer/consumer side: drives the word, the load request and the shift permission.
   modport master (
      output d, load_valid, shift_en,
      input  load_ready, sout, sout_valid, done, busy
   );

   // Transmitter side.
   modport slave (
      input  d, load_valid, shift_en,
      output load_ready, sout, sout_valid, done, busy
   );
endinterface

// File: rtl/piso_32bit.sv
// Parallel-in/serial-out transmitter: takes one WIDTH-bit word on a load handshake
// and shifts it out one bit per permitted clock, then pulses done for one cycle.
module piso_32bit #(
   parameter int WIDTH     = 32,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   piso_32bit_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [CW-1:0]    count_q;
   logic             sout_q;
   logic             sout_valid_q;
   logic             done_q;
   logic             busy_q;
   logic             load_ready_q;

   logic [WIDTH-1:0] shreg_d;
   logic             next_bit_d;
   logic             load_bit_d;

   // Shift toward the output end (zero-filled) and pick the bit that lands there next,
   // so sout can be registered alongside shreg instead of decoded from it.
   always_comb begin
      shreg_d    = '0;
      next_bit_d = 1'b0;
      load_bit_d = 1'b0;
      if (LSB_FIRST) begin
         shreg_d    = shreg_q >> 1;
         next_bit_d = shreg_q[1];
         load_bit_d = bus.d[0];
      end else begin
         shreg_d    = shreg_q << 1;
         next_bit_d = shreg_q[WIDTH-2];
         load_bit_d = bus.d[WIDTH-1];
      end
   end

   // Control FSM with all outputs registered; each branch sets the outputs for the state it enters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         count_q      <= '0;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.load_valid) begin
                  state_q      <= SHIFT;
                  shreg_q      <= bus.d;
                  count_q      <= '0;
                  sout_q       <= load_bit_d;
                  sout_valid_q <= 1'b1;
                  busy_q       <= 1'b1;
                  load_ready_q <= 1'b0;
               end
            end
            SHIFT: begin
               // shift_en low holds everything, so the current bit is re-presented.
               if (bus.shift_en) begin
                  shreg_q <= shreg_d;
                  if (count_q == CW'(WIDTH - 1)) begin
                     // Last bit leaves now; count is parked at 0 so it never passes WIDTH-1.
                     state_q      <= DONE;
                     count_q      <= '0;
                     sout_q       <= 1'b0;
                     sout_valid_q <= 1'b0;
                     done_q       <= 1'b1;
                  end else begin
                     count_q <= count_q + CW'(1);
                     sout_q  <= next_bit_d;
                  end
               end
            end
            DONE: begin
               state_q      <= IDLE;
               done_q       <= 1'b0;
               busy_q       <= 1'b0;
               load_ready_q <= 1'b1;
            end
            default: begin
               state_q      <= IDLE;
               sout_q       <= 1'b0;
               sout_valid_q <= 1'b0;
               done_q       <= 1'b0;
               busy_q       <= 1'b0;
               load_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.sout       = sout_q;
   assign bus.sout_valid = sout_valid_q;
   assign bus.done       = done_q;
   assign bus.busy       = busy_q;
   assign bus.load_ready = load_ready_q;

endmodule

// File: tb/tb_piso_32bit.sv
// Scoreboard bench: stimulus pushes expected bits, done cycles and words; negedge
// monitors compare what each transmitter (LSB-first and MSB-first) presents.
module tb_piso_32bit;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   errs;

   piso_32bit_if #(.WIDTH(32)) ifa ();
   piso_32bit_if #(.WIDTH(32)) ifb ();

   piso_32bit #(.WIDTH(32), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
   piso_32bit #(.WIDTH(32), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

   // Expected serial bits, done cycles and reassembled words per DUT
   logic        qa[$];
   logic        qb[$];
   int          dqa[$];
   int          dqb[$];
   logic [31:0] wqa[$];
   logic [31:0] wqb[$];
   logic [31:0] rxa, rxb;
   int          ka, kb;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic flag(input string nm);
      checks++;
      errs++;
      $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [31:0] w, input int done_cyc);
      for (int i = 0; i < 32; i++) qa.push_back(w[i]);
      dqa.push_back(done_cyc);
      wqa.push_back(w);
   endtask

   task automatic push_b(input logic [31:0] w, input int done_cyc);
      for (int i = 31; i >= 0; i--) qb.push_back(w[i]);
      dqb.push_back(done_cyc);
      wqb.push_back(w);
   endtask

   // Load one word into DUT A; returns the cycle N in which load_valid was accepted.
   task automatic load_a(input logic [31:0] w, input int stall, output int c);
      for (int i = 0; i < 100 && !ifa.load_ready; i++) tick();
      if (!ifa.load_ready) flag("a_load_ready_timeout");
      ifa.d          = w;
      ifa.load_valid = 1'b1;
      c              = cyc;
      push_a(w, c + 33 + stall);
      tick();
      ifa.load_valid = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) tick();
   endtask

   // Monitor A: every valid cycle must show the head expected bit; it is consumed only on shift_en.
   always @(negedge clk) begin
      if (!reset) begin
         if (ifa.sout_valid) begin
            if (qa.size() == 0) flag("a_sout_valid_spurious");
            else begin
               chk("a_sout", {31'b0, ifa.sout}, {31'b0, qa[0]});
               if (ifa.shift_en) begin
                  if (ka < 32) rxa[ka] = qa[0];
                  void'(qa.pop_front());
                  ka++;
               end
            end
         end
         if (ifa.done) begin
            if (dqa.size() == 0) flag("a_done_spurious");
            else begin
               chk("a_done_cycle", cyc, dqa.pop_front());
               chk("a_done_busy_valid", {30'b0, ifa.busy, ifa.sout_valid}, 32'h2);
               chk("a_bit_count", ka, 32);
               chk("a_word", rxa, wqa.pop_front());
            end
            ka = 0;
         end
      end
   end

   // Monitor B: MSB-first, so the k-th received bit is word bit 31-k.
   always @(negedge clk) begin
      if (!reset) begin
         if (ifb.sout_valid) begin
            if (qb.size() == 0) flag("b_sout_valid_spurious");
            else begin
               chk("b_sout", {31'b0, ifb.sout}, {31'b0, qb[0]});
               if (ifb.shift_en) begin
                  if (kb < 32) rxb[31-kb] = qb[0];
                  void'(qb.pop_front());
                  kb++;
               end
            end
         end
         if (ifb.done) begin
            if (dqb.size() == 0) flag("b_done_spurious");
            else begin
               chk("b_done_cycle", cyc, dqb.pop_front());
               chk("b_bit_count", kb, 32);
               chk("b_word", rxb, wqb.pop_front());
            end
            kb = 0;
         end
      end
   end

   initial begin
      int c;
      cyc = 0; checks = 0; errs = 0;
      ka = 0; kb = 0; rxa = '0; rxb = '0;
      reset = 1'b1;
      ifa.d = '0; ifa.load_valid = 1'b0; ifa.shift_en = 1'b1;
      ifb.d = '0; ifb.load_valid = 1'b0; ifb.shift_en = 1'b1;

      // Reset held for 20 time units: outputs idle throughout
      for (int t = 0; t < 3; t++) begin
         #6;
         chk("rst_outputs", {27'b0, ifa.sout, ifa.sout_valid, ifa.done, ifa.busy, ifa.load_ready}, 32'h1);
      end
      #2 reset = 1'b0;
      tick();
      chk("post_rst_outputs", {27'b0, ifa.sout, ifa.sout_valid, ifa.done, ifa.busy, ifa.load_ready}, 32'h1);

      // LSB-first AFAFAFAF: done in N+33, load_ready back in N+34
      load_a(32'hAFAFAFAF, 0, c);
      wait_until(c + 33);
      chk("af_ready_in_done", {31'b0, ifa.load_ready}, 32'h0);
      chk("af_done_high", {31'b0, ifa.done}, 32'h1);
      tick();
      chk("af_ready_back", {31'b0, ifa.load_ready}, 32'h1);
      chk("af_busy_low", {31'b0, ifa.busy}, 32'h0);

      // MSB-first 80000001 on the second instance
      for (int i = 0; i < 100 && !ifb.load_ready; i++) tick();
      ifb.d = 32'h80000001; ifb.load_valid = 1'b1; c = cyc;
      push_b(32'h80000001, c + 33);
      tick();
      ifb.load_valid = 1'b0;
      chk("b_first_bit", {31'b0, ifb.sout}, 32'h1);
      wait_until(c + 34);
      chk("b_ready_back", {31'b0, ifb.load_ready}, 32'h1);

      // 0000FFFF with 3 stall cycles while bit 5 is on sout: done moves to N+36
      load_a(32'h0000FFFF, 3, c);
      wait_until(c + 6);
      ifa.shift_en = 1'b0;
      tick(); tick();
      chk("stall_hold", {30'b0, ifa.sout_valid, ifa.sout}, 32'h3);
      tick();
      ifa.shift_en = 1'b1;
      wait_until(c + 33);
      chk("stall_no_early_done", {31'b0, ifa.done}, 32'h0);
      wait_until(c + 37);
      chk("stall_ready_back", {31'b0, ifa.load_ready}, 32'h1);

      // Asynchronous reset mid-word of DEADBEEF (bit 10 = 1 on sout), then a fresh word
      load_a(32'hDEADBEEF, 0, c);
      wait_until(c + 11);
      chk("pre_rst_bit10", {30'b0, ifa.sout_valid, ifa.sout}, 32'h3);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_outputs", {27'b0, ifa.sout, ifa.sout_valid, ifa.done, ifa.busy, ifa.load_ready}, 32'h1);
      qa.delete(); dqa.delete(); wqa.delete(); ka = 0;
      tick(); tick();
      reset = 1'b0;
      load_a(32'h12345678, 0, c);
      wait_until(c + 34);
      chk("after_rst_ready", {31'b0, ifa.load_ready}, 32'h1);

      // load_valid held high: second word accepted on first IDLE edge, 34 cycles later
      for (int i = 0; i < 100 && !ifa.load_ready; i++) tick();
      ifa.d = 32'hA5A5A5A5; ifa.load_valid = 1'b1; c = cyc;
      push_a(32'hA5A5A5A5, c + 33);
      push_a(32'h5A5A5A5A, c + 67);
      tick();
      ifa.d = 32'h5A5A5A5A;
      wait_until(c + 34);
      chk("b2b_ready_idle", {31'b0, ifa.load_ready}, 32'h1);
      tick();
      ifa.load_valid = 1'b0;
      chk("b2b_second_accepted", {30'b0, ifa.busy, ifa.load_ready}, 32'h2);
      wait_until(c + 69);

      // Drain: every expected bit, done and word must have been seen
      for (int i = 0; i < 200 && (dqa.size() != 0 || dqb.size() != 0); i++) tick();
      chk("drain_qa", qa.size(), 0);
      chk("drain_dqa", dqa.size(), 0);
      chk("drain_qb", qb.size(), 0);
      chk("drain_dqb", dqb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
